// File: rtl/aes_feeder_pkg.sv
// Shared types and helpers for the masked-AES share feeder.
package aes_feeder_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;
    localparam int CNT_W     = 4;
    localparam int WORD_W    = NUM_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        GO,
        LOAD,
        WAIT_DONE
    } feeder_state_t;

    // Byte k of the stream is data byte 15-k: the most significant byte goes first.
    function automatic logic [BYTE_W-1:0] select_byte(input logic [WORD_W-1:0] word,
                                                      input logic [CNT_W-1:0] k);
        return word[BYTE_W*(NUM_BYTES-1-int'(k)) +: BYTE_W];
    endfunction

endpackage

// File: rtl/aes_byte_masker.sv
// Two-share Boolean split of one byte: {byte ^ mask, mask}.
// FEEDER_ZERO_MASK_EN forces the mask to zero so the raw byte is visible on share1.
module aes_byte_masker
    import aes_feeder_pkg::*;
(
    input  logic [BYTE_W-1:0]   data,
    input  logic [BYTE_W-1:0]   mask_rnd,
    output logic [2*BYTE_W-1:0] shared
);

    logic [BYTE_W-1:0] mask;

`ifdef FEEDER_ZERO_MASK_EN
    assign mask = '0;
`else
    assign mask = mask_rnd;
`endif

    assign shared = {data ^ mask, mask};

endmodule

// File: rtl/aes_share_feeder.sv
// Accepts one plaintext/key job, pulses go, streams 16 masked byte pairs, then waits
// for done or a watchdog abort. Build with FEEDER_ZERO_MASK_EN for unmasked debug data.
module aes_share_feeder
    import aes_feeder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 400
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  pt_in,
    input  logic [127:0]  key_in,
    input  logic [15:0]   rnd_in,
    output logic          aes_go,
    output logic [15:0]   pt_shared,
    output logic [15:0]   key_shared,
    input  logic          aes_done,
    output logic          busy,
    output logic          timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    feeder_state_t      state_reg;
    logic [CNT_W-1:0]   byte_cnt_reg;
    logic [WD_W-1:0]    wd_cnt_reg;
    logic [WORD_W-1:0]  pt_reg;
    logic [WORD_W-1:0]  key_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               aes_go_reg;
    logic               timeout_reg;
    logic [15:0]        pt_shared_reg;
    logic [15:0]        key_shared_reg;

    // Shares are registered, so the masker always works on the byte due next cycle.
    logic [CNT_W-1:0]    sel_idx;
    logic [BYTE_W-1:0]   lane_byte   [2];
    logic [2*BYTE_W-1:0] lane_shared [2];

    assign sel_idx      = (state_reg == GO) ? '0 : byte_cnt_reg + CNT_W'(1);
    assign lane_byte[0] = select_byte(pt_reg, sel_idx);
    assign lane_byte[1] = select_byte(key_reg, sel_idx);

    // Lane 0 = plaintext (mask rnd_in[7:0]), lane 1 = key (mask rnd_in[15:8]).
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        aes_byte_masker u_masker (
            .data     (lane_byte[gi]),
            .mask_rnd (rnd_in[gi*BYTE_W +: BYTE_W]),
            .shared   (lane_shared[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            byte_cnt_reg   <= '0;
            wd_cnt_reg     <= '0;
            pt_reg         <= '0;
            key_reg        <= '0;
            in_ready_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            aes_go_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            pt_shared_reg  <= '0;
            key_shared_reg <= '0;
        end else begin
            aes_go_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            pt_shared_reg  <= '0;
            key_shared_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        pt_reg       <= pt_in;
                        key_reg      <= key_in;
                        state_reg    <= GO;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        aes_go_reg   <= 1'b1;
                    end
                end
                GO: begin
                    state_reg      <= LOAD;
                    byte_cnt_reg   <= '0;
                    pt_shared_reg  <= lane_shared[0];
                    key_shared_reg <= lane_shared[1];
                end
                LOAD: begin
                    if (byte_cnt_reg == CNT_W'(NUM_BYTES - 1)) begin
                        state_reg  <= WAIT_DONE;
                        wd_cnt_reg <= '0;
                    end else begin
                        byte_cnt_reg   <= byte_cnt_reg + CNT_W'(1);
                        pt_shared_reg  <= lane_shared[0];
                        key_shared_reg <= lane_shared[1];
                    end
                end
                WAIT_DONE: begin
                    // A done seen on the limit cycle leaves the timeout pulse unset.
                    if (aes_done || timeout_reg) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_reg <= 1'b1;
                        end
                        if (wd_cnt_reg != WD_W'(TIMEOUT_CYCLES)) begin
                            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign busy       = busy_reg;
    assign aes_go     = aes_go_reg;
    assign timeout    = timeout_reg;
    assign pt_shared  = pt_shared_reg;
    assign key_shared = key_shared_reg;

endmodule

// File: tb/tb_aes_share_feeder.sv
// Directed bench for aes_share_feeder: zero vector, FIPS-197 vector, ignored inputs,
// watchdog abort and mid-stream reset. Outputs are sampled on the falling edge.
module tb_aes_share_feeder;

    localparam int TO_CYC = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic [15:0]  rnd_in;
    logic         aes_go;
    logic [15:0]  pt_shared;
    logic [15:0]  key_shared;
    logic         aes_done;
    logic         busy;
    logic         timeout;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes_share_feeder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pt_in      (pt_in),
        .key_in     (key_in),
        .rnd_in     (rnd_in),
        .aes_go     (aes_go),
        .pt_shared  (pt_shared),
        .key_shared (key_shared),
        .aes_done   (aes_done),
        .busy       (busy),
        .timeout    (timeout)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] next_rnd(input bit fixed_rnd);
        return fixed_rnd ? 16'hA55A : 16'($urandom);
    endfunction

    // Starts at a falling edge with the feeder idle; ends at the falling edge of the last
    // LOAD cycle, or one cycle after a reset injected at stream byte abort_k.
    task automatic run_job(input logic [127:0] pt, input logic [127:0] key, input bit fixed_rnd,
                           input int intrude_k, input int abort_k);
        logic [15:0] r_prev;
        logic [7:0]  mp, mk, bp, bk;
        check_eq("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        pt_in    = pt;
        key_in   = key;
        rnd_in   = next_rnd(fixed_rnd);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("go_pulse", aes_go, 1);
        check_eq("go_ready", in_ready, 0);
        check_eq("go_busy", busy, 1);
        check_eq("go_pt_zero", pt_shared, 0);
        rnd_in = next_rnd(fixed_rnd);
        r_prev = rnd_in;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            aes_done = 1'b0;
`ifdef FEEDER_ZERO_MASK_EN
            mp = 8'h00;
            mk = 8'h00;
`else
            mp = r_prev[7:0];
            mk = r_prev[15:8];
`endif
            bp = pt[8*(15-k) +: 8];
            bk = key[8*(15-k) +: 8];
            check_eq($sformatf("pt_byte%0d", k), pt_shared, {bp ^ mp, mp});
            check_eq($sformatf("key_byte%0d", k), key_shared, {bk ^ mk, mk});
            check_eq("load_ready", in_ready, 0);
            if (k == 0) check_eq("go_once", aes_go, 0);
            if (k == abort_k) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq("abort_busy", busy, 0);
                check_eq("abort_pt", pt_shared, 0);
                check_eq("abort_go", aes_go, 0);
                check_eq("abort_ready", in_ready, 1);
                $display("job pt=%h aborted by reset at byte %0d", pt, k);
                return;
            end
            if (k == intrude_k) begin
                in_valid = 1'b1;
                pt_in    = ~pt;
                aes_done = 1'b1;
            end
            rnd_in = next_rnd(fixed_rnd);
            r_prev = rnd_in;
        end
        in_valid = 1'b0;
        aes_done = 1'b0;
    endtask

    // Call right after a full stream; done is raised in the delay-th WAIT_DONE cycle.
    task automatic finish_done(input int delay, input logic [127:0] pt);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_eq("wait_ready", in_ready, 0);
            check_eq("wait_pt_zero", pt_shared, 0);
            check_eq("wait_key_zero", key_shared, 0);
            if (i == delay - 1) aes_done = 1'b1;
        end
        @(negedge clk);
        aes_done = 1'b0;
        check_eq("done_ready", in_ready, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_no_timeout", timeout, 0);
        $display("job pt=%h completed with done after %0d wait cycles", pt, delay);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        pt_in    = '0;
        key_in   = '0;
        rnd_in   = '0;
        aes_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_go", aes_go, 0);
        check_eq("rst_pt", pt_shared, 0);
        check_eq("rst_key", key_shared, 0);
        check_eq("rst_timeout", timeout, 0);

        // All-zero job with constant randomness.
        run_job('0, '0, 1'b1, -1, -1);
        finish_done(3, '0);

        // FIPS-197 vector, re-accepted as early as possible afterwards.
        run_job(FIPS_PT, FIPS_KEY, 1'b0, -1, -1);
        finish_done(1, FIPS_PT);

        // in_valid and aes_done during LOAD are both ignored.
        run_job(FIPS_PT, FIPS_KEY, 1'b0, 4, -1);
        finish_done(5, FIPS_PT);
        run_job(~FIPS_PT, FIPS_KEY, 1'b0, -1, -1);
        finish_done(2, ~FIPS_PT);

        // Watchdog: no done at all.
        run_job(FIPS_PT, FIPS_KEY, 1'b0, -1, -1);
        for (int n = 0; n <= TO_CYC; n++) begin
            @(negedge clk);
            check_eq($sformatf("timeout_w%0d", n), timeout, (n == TO_CYC) ? 1 : 0);
        end
        @(negedge clk);
        check_eq("timeout_clear", timeout, 0);
        check_eq("timeout_ready", in_ready, 1);
        check_eq("timeout_busy", busy, 0);
        $display("job pt=%h ended by watchdog after %0d cycles", FIPS_PT, TO_CYC);

        // Reset in the middle of the stream, then a normal job.
        run_job(FIPS_PT, FIPS_KEY, 1'b0, -1, 7);
        @(negedge clk);
        check_eq("post_abort_go", aes_go, 0);
        check_eq("post_abort_ready", in_ready, 1);
        run_job(FIPS_KEY, FIPS_PT, 1'b0, -1, -1);
        finish_done(1, FIPS_KEY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/aes_share_feeder.md
Name: aes_share_feeder

Overview:
- Upstream stage of the round-based masked AES core (full_AES).
- Accepts one unshared 128-bit plaintext and one 128-bit key through a valid/ready handshake.
- Splits both into two Boolean shares using fresh randomness, pulses go, then streams 16 cycles of byte-serial shared data in the core's 16-bit {share1, share0} format.
- Holds off the next job until the core reports done or a timeout fires.

Parameters:
- NUM_BYTES, 16, bytes streamed per block.
- BYTE_W, 8, bits per byte per share.
- TIMEOUT_CYCLES, 400, maximum cycles in WAIT_DONE before abort; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pt_in/key_in valid.
- in_ready  output  1  feeder can accept a job.
- pt_in  input  128  unshared plaintext; byte 15 = [127:120].
- key_in  input  128  unshared key, same byte order.
- rnd_in  input  16  fresh randomness each cycle: [7:0] = pt mask byte, [15:8] = key mask byte.
- aes_go  output  1  one-cycle start pulse to the core.
- pt_shared  output  16  {pt_byte^mask, mask}.
- key_shared  output  16  {key_byte^mask, mask}.
- aes_done  input  1  core completion.
- busy  output  1  high in any state other than IDLE.
- timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset: state = IDLE, counters = 0, all outputs 0, except in_ready = 1 in the first cycle after reset deasserts. Reset in any state aborts immediately; no go pulse or data follows.
- FSM states: IDLE, GO, LOAD, WAIT_DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch pt_in/key_in and go to GO.
  - GO: aes_go = 1 for exactly one cycle, then LOAD with byte_cnt = 0.
  - LOAD: lasts exactly NUM_BYTES cycles. byte_cnt increments each cycle; after byte_cnt = NUM_BYTES-1, go to WAIT_DONE.
  - WAIT_DONE: aes_done = 1 → IDLE. Watchdog reaching TIMEOUT_CYCLES without aes_done → timeout = 1 for one cycle, then IDLE.
- Timing relative to the accept cycle T:
  - aes_go high in T+1.
  - Byte k (k = 0..15) presented in T+2+k, MSB byte first, i.e. data byte index 15-k.
  - in_ready returns to 1 the cycle after done or timeout is seen, so the earliest re-accept is one cycle after that.
- Masking:
  - pt_shared and key_shared are registered.
  - The value presented in cycle c uses rnd_in sampled in cycle c-1.
  - share0 = mask, share1 = byte ^ mask, i.e. [15:8] = masked byte, [7:0] = mask.
  - Outside LOAD both outputs are 16'h0000.
- in_valid outside IDLE is ignored; the job is not accepted and is not queued.
- aes_done in IDLE, GO or LOAD is ignored and is not remembered.
- aes_done and timeout reaching their condition in the same cycle: done wins, timeout stays 0.
- Watchdog counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to WAIT_DONE.
  - Saturates and never wraps.
- byte_cnt is 4 bits and never wraps mid-stream.

Optional Feature:
- Macro: FEEDER_ZERO_MASK_EN.
- Defined: mask forced to 8'h00, so share0 = 0 and share1 = raw byte; rnd_in is ignored. For waveform debug of unmasked data.
- Undefined: masks are taken from rnd_in as specified above.

Decomposition:
- Package aes_feeder_pkg holds:
  - the state enum {IDLE, GO, LOAD, WAIT_DONE};
  - BYTE_W and NUM_BYTES constants;
  - a function selecting byte index 15-k from a 128-bit word.
- Sub-module aes_byte_masker: combinational {data^mask, mask} for one byte. Instantiated twice (pt, key); it contains the FEEDER_ZERO_MASK_EN switch.

Test Plan:
- All-zero pt/key, rnd_in held at 16'hA55A → aes_go in T+1; for 16 cycles pt_shared = 16'h5A5A and key_shared = 16'hA5A5; in_ready = 0 until aes_done.
- FIPS-197 vector pt = 00112233445566778899aabbccddeeff, key = 000102030405060708090a0b0c0d0e0f, random rnd_in → XOR of share halves yields pt 00,11,…,ff and key 00,01,…,0f in order; reassembled core output = 69c4e0d86a7b0430d8cdb78070b4c55a.
- in_valid pulsed during LOAD with a different pt → ignored; the streamed bytes are unchanged; the second job is accepted only after aes_done.
- aes_done never asserted, TIMEOUT_CYCLES = 20 → timeout pulses exactly 20 cycles after WAIT_DONE entry; in_ready = 1 on the following cycle.
- reset asserted at LOAD byte 7 → the next cycle shows busy = 0, pt_shared = 0, aes_go = 0, in_ready = 1; a new job then runs normally.
- With FEEDER_ZERO_MASK_EN defined and the FIPS vector → pt_shared[7:0] = 0 throughout; pt_shared[15:8] = 00,11,…,ff.
